// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the byte-addressed data memory.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  function automatic int unsigned byte_off_width(input int unsigned word_size);
    return $clog2(word_size / 8);
  endfunction

  // One bit of the lane-enable mask: lane is covered by an access of the
  // given size starting at byte lane off.
  function automatic logic lane_enable(input logic [1:0]  size,
                                       input int unsigned off,
                                       input int unsigned lane,
                                       input int unsigned nlanes);
    int unsigned span;
    case (size)
      SIZE_BYTE: span = 1;
      SIZE_HALF: span = 2;
      default:   span = nlanes;
    endcase
    return (lane >= off) && (lane < off + span);
  endfunction

endpackage

// File: rtl/mem_byte_lane_ram.sv
// DEPTH x WORD_SIZE storage with per-byte write enables and a registered read port.
module mem_byte_lane_ram #(
  parameter int WORD_SIZE = 32,
  parameter int DEPTH     = 1024
) (
  input  logic                       clock,
  input  logic [WORD_SIZE/8-1:0]     wr_en,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [WORD_SIZE-1:0]       wr_data,
  input  logic                       rd_en,
  output logic [WORD_SIZE-1:0]       rd_data
);

  localparam int NLANES = WORD_SIZE / 8;

  logic [WORD_SIZE-1:0] mem_q [DEPTH];
  logic [WORD_SIZE-1:0] rd_data_q;
  logic [WORD_SIZE-1:0] rd_data_d;

  // Read data only moves on a read, so a held response stays stable.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[addr];
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NLANES; i++) begin
      if (wr_en[i]) mem_q[addr][i*8 +: 8] <= wr_data[i*8 +: 8];
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/byte_addr_memory.sv
// Byte-addressed data memory: request decode, fault detection, one-slot
// response register with backpressure and load extension.
module byte_addr_memory
  import mem_pkg::*;
#(
  parameter int WORD_SIZE  = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [WORD_SIZE-1:0]  req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WORD_SIZE-1:0]  resp_data,
  output logic                  resp_error,
  output logic                  err_sticky,
  input  logic                  err_clear
);

  localparam int unsigned NLANES = WORD_SIZE / 8;
  localparam int          OFF_W  = byte_off_width(WORD_SIZE);
  localparam int          IDX_W  = $clog2(DEPTH);

  function automatic logic [WORD_SIZE-1:0] extend_byte(input logic [7:0] b, input logic sgn);
    return sgn ? WORD_SIZE'(signed'(b)) : WORD_SIZE'(b);
  endfunction

  function automatic logic [WORD_SIZE-1:0] extend_half(input logic [15:0] h, input logic sgn);
    return sgn ? WORD_SIZE'(signed'(h)) : WORD_SIZE'(h);
  endfunction

  logic [OFF_W-1:0]     addr_off;
  logic [OFF_W-1:0]     lane_off;
  logic [IDX_W-1:0]     word_idx;
  logic                 out_of_range;
  logic                 misaligned;
  logic                 bad_size;
  logic                 fault;
  logic                 accept;
  logic                 do_write;
  logic                 do_read;
  logic [NLANES-1:0]    lane_mask;
  logic [NLANES-1:0]    wr_en;
  logic [WORD_SIZE-1:0] wdata_lane;
  logic [WORD_SIZE-1:0] rd_data;

  assign addr_off = req_address[OFF_W-1:0];
  assign word_idx = req_address[OFF_W +: IDX_W];

  generate
    if (ADDR_WIDTH > OFF_W + IDX_W) begin : g_range
      assign out_of_range = |req_address[ADDR_WIDTH-1:OFF_W+IDX_W];
    end else begin : g_no_range
      assign out_of_range = 1'b0;
    end
  endgenerate

  always_comb begin
    bad_size   = 1'b0;
    misaligned = 1'b0;
    lane_off   = addr_off;
    case (req_size)
      SIZE_BYTE: lane_off = addr_off;
      SIZE_HALF: misaligned = addr_off[0];
      SIZE_WORD: begin
        misaligned = |addr_off;
        lane_off   = '0;
      end
      default:   bad_size = 1'b1;
    endcase
  end

  assign fault     = out_of_range | misaligned | bad_size;
  assign req_ready = !resp_valid || resp_ready;
  assign accept    = req_valid && req_ready;
  // A request coinciding with reset must not touch the array.
  assign do_write  = accept && req_write && !fault && reset_n;
  assign do_read   = accept && !req_write && !fault && reset_n;

  always_comb begin
    lane_mask = '0;
    for (int unsigned i = 0; i < NLANES; i++) begin
      lane_mask[i] = lane_enable(req_size, 32'(lane_off), i, NLANES);
    end
  end

  assign wr_en      = do_write ? lane_mask : '0;
  assign wdata_lane = req_wdata << {lane_off, 3'b000};

  mem_byte_lane_ram #(
    .WORD_SIZE (WORD_SIZE),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .addr    (word_idx),
    .wr_data (wdata_lane),
    .rd_en   (do_read),
    .rd_data (rd_data)
  );

  logic             resp_valid_q, resp_valid_d;
  logic             resp_error_q, resp_error_d;
  logic             load_ok_q,    load_ok_d;
  logic             err_q,        err_d;
  logic [1:0]       size_q,       size_d;
  logic [OFF_W-1:0] off_q,        off_d;
  logic             signed_q,     signed_d;

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_error_d = resp_error_q;
    load_ok_d    = load_ok_q;
    size_d       = size_q;
    off_d        = off_q;
    signed_d     = signed_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_error_d = fault;
      load_ok_d    = !req_write && !fault;
      size_d       = req_size;
      off_d        = lane_off;
      signed_d     = req_signed;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
    // A new fault takes priority over a simultaneous clear.
    err_d = err_q;
    if (err_clear)       err_d = 1'b0;
    if (accept && fault) err_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      load_ok_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      load_ok_q    <= load_ok_d;
      err_q        <= err_d;
    end
    size_q   <= size_d;
    off_q    <= off_d;
    signed_q <= signed_d;
  end

  always_comb begin
    resp_data = '0;
    if (load_ok_q) begin
      case (size_q)
        SIZE_BYTE: resp_data = extend_byte(rd_data[{off_q, 3'b000} +: 8], signed_q);
        SIZE_HALF: resp_data = extend_half(rd_data[{off_q, 3'b000} +: 16], signed_q);
        default:   resp_data = rd_data;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign err_sticky = err_q;

endmodule

// File: doc/byte_addr_memory.md
Name: byte_addr_memory

Overview:
- Parametrised successor to the single-word data memory: a byte-addressed word-organised RAM for the MIPS datapath supporting byte, halfword and word loads and stores.
- Adds a valid/ready request channel, a registered one-entry response with backpressure, sign/zero extension on loads, and misalignment and out-of-range detection with a sticky error flag.
- Sits between the MEM pipeline stage and the storage array.

Parameters:
- WORD_SIZE, 32, data word width in bits; multiple of 8, power of two, at least 16.
- DEPTH, 1024, number of words; power of two.
- ADDR_WIDTH, 32, byte address width.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is illegal.
- req_signed  in  1  loads only: sign-extend (1) or zero-extend (0).
- req_address  in  ADDR_WIDTH  byte address.
- req_wdata  in  WORD_SIZE  store data; the low bytes are used for byte and half stores.
- resp_valid  out  1  response held in register.
- resp_ready  in  1  consumer takes the response.
- resp_data  out  WORD_SIZE  extended load data; 0 for stores and for faults.
- resp_error  out  1  this response faulted.
- err_sticky  out  1  set by any fault; cleared by err_clear.
- err_clear  in  1  clears err_sticky.

Behaviour:
- Reset (reset_n = 0 at posedge): resp_valid = 0, resp_data = 0, resp_error = 0, err_sticky = 0. Array contents are not reset.
- req_ready is combinational: !resp_valid || resp_ready. Single response slot; full throughput when resp_ready is held high.
- Accept cycle N: the array read/write and the response register load both happen at posedge N. resp_valid = 1 from cycle N+1, so load latency is 1 cycle.
- Response is held stable, with all fields unchanged, until resp_valid && resp_ready. If that handshake and a new accept occur in the same cycle, the new response replaces the old one and resp_valid stays 1.
- Layout is little-endian. Word index = req_address >> log2(WORD_SIZE/8); byte lane = low address bits.
- Half and word accesses use the lane at offset (addr mod size).
- Fault conditions:
  - Misaligned: half with addr[0] set; word with low log2(WORD_SIZE/8) bits nonzero.
  - Out of range: word index >= DEPTH.
  - Illegal size: req_size = 11.
- On a fault: no array write, resp_error = 1, resp_data = 0.
- Stores write only the addressed byte lanes via per-lane enables; other lanes are preserved.
- Loads extract the lane(s) and extend to WORD_SIZE according to req_signed. Word loads ignore req_signed.
- A load accepted the cycle after a store to the same word returns the stored data; there is no stale read.
- err_sticky: set at the posedge of any accepted faulting request. err_clear clears it. If clear and a new fault coincide, the set wins.
- reset_n low mid-transaction drops any pending response (resp_valid = 0). A store accepted in the same cycle as reset is not performed.
- Requests are ignored while req_valid = 0 or req_ready = 0. Inputs need not be held stable when they are not accepted.

Decomposition:
- Shared package mem_pkg holds:
  - Size encodings: SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b10.
  - The function computing lane-enable masks.
  - The function computing the byte-offset width log2(WORD_SIZE/8).
- Sub-module mem_byte_lane_ram: a DEPTH x WORD_SIZE array with a per-byte write-enable vector and a synchronous read port. The control/response logic stays in byte_addr_memory.

Test Plan:
- Store word 0xDEADBEEF at 0x10, then load word 0x10 -> resp_data = 0xDEADBEEF, resp_error = 0, one cycle after accept.
- Store byte 0x80 at 0x13, then load byte 0x13 signed -> 0xFFFFFF80; unsigned -> 0x00000080; load word 0x10 -> 0x80ADBEEF.
- Load half at 0x11 -> resp_error = 1, resp_data = 0, err_sticky = 1. Store word at 0x1002 (DEPTH = 1024) -> error, and word 0x1000 mod range is unchanged. Assert err_clear -> err_sticky = 0.
- Hold resp_ready = 0 for 5 cycles after a load -> req_ready = 0 and the response is stable. Release -> next request is accepted in the same cycle and back-to-back throughput is 1 per cycle.
- req_size = 11 -> error response. Fault coincident with err_clear -> err_sticky = 1.
- Assert reset_n = 0 while resp_valid = 1 -> resp_valid = 0 next cycle. A store issued in the reset cycle leaves memory unchanged.
